// File: rtl/buffer_quadro_matriz_if.sv
// Signal bundle between the frame writer / row scanner and the double-buffered
// 5x7 frame store. The master side drives writes, commit, clear, the frame
// boundary and the row being scanned; the slave side is the frame store.
interface buffer_quadro_matriz_if;
  logic       wr_en;
  logic [2:0] wr_linha;
  logic [4:0] wr_dado;
  logic       commit;
  logic       limpar;
  logic       fim_quadro;
  logic [2:0] rd_linha;
  logic [4:0] rd_colunas;
  logic       pronto;
  logic       quadro_ativo;
  logic       troca;

  modport master (
    output wr_en, wr_linha, wr_dado, commit, limpar, fim_quadro, rd_linha,
    input  rd_colunas, pronto, quadro_ativo, troca
  );

  modport slave (
    input  wr_en, wr_linha, wr_dado, commit, limpar, fim_quadro, rd_linha,
    output rd_colunas, pronto, quadro_ativo, troca
  );
endinterface

// File: rtl/buffer_quadro_matriz.sv
// Double-buffered 5x7 frame store for the LED matrix. New frames are written
// into the hidden bank; a commit is held until the scanner reports a frame
// boundary, so the visible bank only ever changes between two full scans.
module buffer_quadro_matriz (
  input  logic                         clock_50MHz,
  input  logic                         reset,
  buffer_quadro_matriz_if.slave        bus
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    LIMPANDO = 2'd1,
    PENDENTE = 2'd2
  } estado_t;

  estado_t    estado;
  estado_t    proximo_estado;

  logic [4:0] banco [2][7];
  logic [2:0] contador_limpeza;
  logic       quadro_ativo_q;
  logic       troca_q;
  logic [4:0] rd_colunas_q;

  logic       banco_oculto;
  logic       aceita_escrita;
  logic       limpa_linha;
  logic       faz_troca;
  logic       pronto_c;

  // Row index 7 does not exist; such writes are simply never performed.
  assign banco_oculto = ~quadro_ativo_q;

  // State register; reset discards any pending commit or clear in progress.
  always_ff @(posedge clock_50MHz) begin
    if (reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= proximo_estado;
    end
  end

  // Next-state logic: clear beats commit, and a commit waits for a frame boundary.
  always_comb begin
    proximo_estado = estado;
    case (estado)
      OCIOSO: begin
        if (bus.limpar) begin
          proximo_estado = LIMPANDO;
        end else if (bus.commit) begin
          proximo_estado = PENDENTE;
        end
      end
      LIMPANDO: begin
        if (contador_limpeza == 3'd6) begin
          proximo_estado = OCIOSO;
        end
      end
      PENDENTE: begin
        if (bus.fim_quadro) begin
          proximo_estado = OCIOSO;
        end
      end
      default: proximo_estado = OCIOSO;
    endcase
  end

  // Per-state strobes: only the idle state touches the back bank from outside.
  always_comb begin
    pronto_c       = 1'b0;
    aceita_escrita = 1'b0;
    limpa_linha    = 1'b0;
    faz_troca      = 1'b0;
    case (estado)
      OCIOSO: begin
        pronto_c       = 1'b1;
        aceita_escrita = bus.wr_en && (bus.wr_linha != 3'd7);
      end
      LIMPANDO: begin
        limpa_linha = 1'b1;
      end
      PENDENTE: begin
        faz_troca = bus.fim_quadro;
      end
      default: begin
        pronto_c = 1'b0;
      end
    endcase
  end

  // Clear row counter: sits at 0 outside a clear, walks rows 0..6 during one.
  always_ff @(posedge clock_50MHz) begin
    if (reset || (estado != LIMPANDO)) begin
      contador_limpeza <= 3'd0;
    end else begin
      contador_limpeza <= contador_limpeza + 3'd1;
    end
  end

  // Bank storage: external writes and clear rows both land in the hidden bank.
  always_ff @(posedge clock_50MHz) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 7; r++) begin
          banco[b][r] <= 5'd0;
        end
      end
    end else if (aceita_escrita) begin
      banco[banco_oculto][bus.wr_linha] <= bus.wr_dado;
    end else if (limpa_linha) begin
      banco[banco_oculto][contador_limpeza] <= 5'd0;
    end
  end

  // Bank swap and its one-cycle notification pulse.
  always_ff @(posedge clock_50MHz) begin
    if (reset) begin
      quadro_ativo_q <= 1'b0;
      troca_q        <= 1'b0;
    end else begin
      troca_q <= faz_troca;
      if (faz_troca) begin
        quadro_ativo_q <= ~quadro_ativo_q;
      end
    end
  end

  // Registered front-bank read for the scanner; the nonexistent row 7 reads dark.
  always_ff @(posedge clock_50MHz) begin
    if (reset) begin
      rd_colunas_q <= 5'd0;
    end else if (bus.rd_linha == 3'd7) begin
      rd_colunas_q <= 5'd0;
    end else begin
      rd_colunas_q <= banco[quadro_ativo_q][bus.rd_linha];
    end
  end

  assign bus.rd_colunas   = rd_colunas_q;
  assign bus.pronto       = pronto_c;
  assign bus.quadro_ativo = quadro_ativo_q;
  assign bus.troca        = troca_q;

endmodule

// File: tb/tb_buffer_quadro_matriz.sv
// Self-checking bench for the double-buffered 5x7 frame store. Directed
// scenarios plus a randomized run against a frame-level reference model.
module tb_buffer_quadro_matriz;

  logic clock_50MHz = 1'b0;
  logic reset       = 1'b1;

  buffer_quadro_matriz_if bus ();

  buffer_quadro_matriz dut (
    .clock_50MHz (clock_50MHz),
    .reset       (reset),
    .bus         (bus)
  );

  always #5 clock_50MHz = ~clock_50MHz;

  int checks   = 0;
  int failures = 0;

  // Reference model: two frames, which one is shown, whether a commit is
  // waiting, and how many rows of a clear are still to go.
  logic [4:0] m_bank [2][7];
  int         m_front;
  bit         m_pending;
  int         m_clear_left;
  logic [4:0] m_rd;
  logic       m_troca;

  function automatic void model_step();
    int back;
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 7; r++)
          m_bank[b][r] = 5'd0;
      m_front = 0; m_pending = 0; m_clear_left = 0; m_rd = 5'd0; m_troca = 1'b0;
      return;
    end
    back    = 1 - m_front;
    m_rd    = (bus.rd_linha == 3'd7) ? 5'd0 : m_bank[m_front][int'(bus.rd_linha)];
    m_troca = 1'b0;
    if (m_clear_left > 0) begin
      m_bank[back][7 - m_clear_left] = 5'd0;
      m_clear_left--;
    end else if (m_pending) begin
      if (bus.fim_quadro) begin
        m_front   = back;
        m_pending = 0;
        m_troca   = 1'b1;
      end
    end else begin
      if (bus.wr_en && bus.wr_linha != 3'd7)
        m_bank[back][int'(bus.wr_linha)] = bus.wr_dado;
      if (bus.limpar)
        m_clear_left = 7;
      else if (bus.commit)
        m_pending = 1;
    end
  endfunction

  task automatic tick();
    @(posedge clock_50MHz);
    model_step();
    #1;
  endtask

  task automatic idle();
    bus.wr_en = 1'b0; bus.wr_linha = 3'd0; bus.wr_dado = 5'd0;
    bus.commit = 1'b0; bus.limpar = 1'b0; bus.fim_quadro = 1'b0;
    bus.rd_linha = 3'd0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic write_row(input logic [2:0] r, input logic [4:0] d);
    bus.wr_en = 1'b1; bus.wr_linha = r; bus.wr_dado = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    bus.commit = 1'b1; tick(); bus.commit = 1'b0;
  endtask

  task automatic pulse_fim();
    bus.fim_quadro = 1'b1; tick(); bus.fim_quadro = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int r = 0; r < 8; r++) begin
      bus.rd_linha = 3'(r);
      tick();
      checks++;
      if (bus.rd_colunas !== 5'd0) begin
        failures++; $display("[TB] FAIL reset_rd row=%0d got=%h want=00", r, bus.rd_colunas);
      end
      checks++;
      if (bus.quadro_ativo !== 1'b0 || bus.pronto !== 1'b1 || bus.troca !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_flags row=%0d got qa=%b pronto=%b troca=%b want 0/1/0",
                 r, bus.quadro_ativo, bus.pronto, bus.troca);
      end
    end
  endtask

  task automatic test_write_commit();
    logic [4:0] pat [7] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h1F, 5'h15};
    do_reset();
    for (int k = 0; k < 7; k++) write_row(3'(k), pat[k]);
    pulse_commit();
    checks++;
    if (bus.pronto !== 1'b0) begin
      failures++; $display("[TB] FAIL commit_pronto got=%b want=0", bus.pronto);
    end
    for (int i = 0; i < 5; i++) begin
      bus.rd_linha = 3'(i);
      tick();
      checks++;
      if (bus.rd_colunas !== 5'd0 || bus.quadro_ativo !== 1'b0 || bus.troca !== 1'b0) begin
        failures++;
        $display("[TB] FAIL preswap row=%0d got rd=%h qa=%b troca=%b want 00/0/0",
                 i, bus.rd_colunas, bus.quadro_ativo, bus.troca);
      end
    end
    pulse_fim();
    checks++;
    if (bus.quadro_ativo !== 1'b1 || bus.troca !== 1'b1 || bus.pronto !== 1'b1) begin
      failures++;
      $display("[TB] FAIL swap got qa=%b troca=%b pronto=%b want 1/1/1",
               bus.quadro_ativo, bus.troca, bus.pronto);
    end
    for (int k = 0; k < 7; k++) begin
      bus.rd_linha = 3'(k);
      tick();
      checks++;
      if (bus.rd_colunas !== pat[k]) begin
        failures++; $display("[TB] FAIL postswap row=%0d got=%h want=%h", k, bus.rd_colunas, pat[k]);
      end
      checks++;
      if (bus.troca !== 1'b0) begin
        failures++; $display("[TB] FAIL troca_width cycle=%0d got=%b want=0", k, bus.troca);
      end
    end
  endtask

  task automatic test_commit_boundary();
    do_reset();
    write_row(3'd3, 5'h0A);
    bus.commit = 1'b1; bus.fim_quadro = 1'b1;
    tick();
    bus.commit = 1'b0; bus.fim_quadro = 1'b0;
    checks++;
    if (bus.quadro_ativo !== 1'b0 || bus.pronto !== 1'b0) begin
      failures++;
      $display("[TB] FAIL same_cycle_noswap got qa=%b pronto=%b want 0/0", bus.quadro_ativo, bus.pronto);
    end
    tick();
    checks++;
    if (bus.troca !== 1'b0) begin
      failures++; $display("[TB] FAIL same_cycle_troca got=%b want=0", bus.troca);
    end
    pulse_fim();
    checks++;
    if (bus.quadro_ativo !== 1'b1 || bus.troca !== 1'b1) begin
      failures++;
      $display("[TB] FAIL next_fim_swap got qa=%b troca=%b want 1/1", bus.quadro_ativo, bus.troca);
    end
    bus.rd_linha = 3'd3;
    tick();
    checks++;
    if (bus.rd_colunas !== 5'h0A) begin
      failures++; $display("[TB] FAIL boundary_read got=%h want=0a", bus.rd_colunas);
    end
  endtask

  task automatic test_pending_drops();
    logic [4:0] fa [7];
    logic [4:0] fb [7];
    do_reset();
    for (int k = 0; k < 7; k++) begin
      fa[k] = 5'(5'h10 + k);
      fb[k] = 5'(5'h01 + k);
    end
    for (int k = 0; k < 7; k++) write_row(3'(k), fa[k]);
    pulse_commit();
    pulse_fim();
    for (int k = 0; k < 7; k++) write_row(3'(k), fb[k]);
    pulse_commit();
    bus.wr_en = 1'b1; bus.wr_linha = 3'd2; bus.wr_dado = 5'h1F; bus.limpar = 1'b1;
    tick();
    bus.wr_en = 1'b0; bus.limpar = 1'b0;
    checks++;
    if (bus.pronto !== 1'b0) begin
      failures++; $display("[TB] FAIL pending_pronto got=%b want=0", bus.pronto);
    end
    pulse_fim();
    checks++;
    if (bus.troca !== 1'b1 || bus.quadro_ativo !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pending_swap got troca=%b qa=%b want 1/0", bus.troca, bus.quadro_ativo);
    end
    bus.rd_linha = 3'd2;
    tick();
    checks++;
    if (bus.rd_colunas !== fb[2]) begin
      failures++; $display("[TB] FAIL dropped_write got=%h want=%h", bus.rd_colunas, fb[2]);
    end
    pulse_commit();
    pulse_fim();
    for (int k = 0; k < 7; k++) begin
      bus.rd_linha = 3'(k);
      tick();
      checks++;
      if (bus.rd_colunas !== fa[k]) begin
        failures++; $display("[TB] FAIL old_frame row=%0d got=%h want=%h", k, bus.rd_colunas, fa[k]);
      end
    end
  endtask

  task automatic test_clear();
    int cnt;
    do_reset();
    for (int k = 0; k < 7; k++) write_row(3'(k), 5'h1F);
    bus.limpar = 1'b1;
    tick();
    bus.limpar = 1'b0;
    cnt = 0;
    while (bus.pronto === 1'b0 && cnt < 20) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt != 7) begin
      failures++; $display("[TB] FAIL clear_length got=%0d want=7", cnt);
    end
    write_row(3'd7, 5'h1F);
    pulse_commit();
    pulse_fim();
    checks++;
    if (bus.quadro_ativo !== 1'b1) begin
      failures++; $display("[TB] FAIL clear_swap got qa=%b want=1", bus.quadro_ativo);
    end
    for (int k = 0; k < 8; k++) begin
      bus.rd_linha = 3'(k);
      tick();
      checks++;
      if (bus.rd_colunas !== 5'd0) begin
        failures++; $display("[TB] FAIL cleared_row row=%0d got=%h want=00", k, bus.rd_colunas);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int scen = 0; scen < 2; scen++) begin
      do_reset();
      for (int k = 0; k < 7; k++) write_row(3'(k), 5'h1F);
      if (scen == 0) begin
        bus.limpar = 1'b1; tick(); bus.limpar = 1'b0;
        tick(); tick();
      end else begin
        pulse_commit();
        tick();
      end
      reset = 1'b1; tick(); reset = 1'b0;
      checks++;
      if (bus.pronto !== 1'b1 || bus.quadro_ativo !== 1'b0 || bus.troca !== 1'b0) begin
        failures++;
        $display("[TB] FAIL midreset_flags scen=%0d got pronto=%b qa=%b troca=%b want 1/0/0",
                 scen, bus.pronto, bus.quadro_ativo, bus.troca);
      end
      pulse_fim();
      tick();
      checks++;
      if (bus.quadro_ativo !== 1'b0 || bus.troca !== 1'b0) begin
        failures++;
        $display("[TB] FAIL midreset_noswap scen=%0d got qa=%b troca=%b want 0/0",
                 scen, bus.quadro_ativo, bus.troca);
      end
      pulse_commit();
      pulse_fim();
      for (int k = 0; k < 7; k++) begin
        bus.rd_linha = 3'(k);
        tick();
        checks++;
        if (bus.rd_colunas !== 5'd0) begin
          failures++;
          $display("[TB] FAIL midreset_bank scen=%0d row=%0d got=%h want=00", scen, k, bus.rd_colunas);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      reset          = ($urandom_range(0, 79) == 0);
      bus.wr_en      = $urandom_range(0, 1) == 1;
      bus.wr_linha   = 3'($urandom_range(0, 7));
      bus.wr_dado    = 5'($urandom);
      bus.commit     = ($urandom_range(0, 7) == 0);
      bus.limpar     = ($urandom_range(0, 19) == 0);
      bus.fim_quadro = ($urandom_range(0, 5) == 0);
      bus.rd_linha   = 3'($urandom_range(0, 7));
      tick();
      checks++;
      if (bus.rd_colunas !== m_rd) begin
        failures++; $display("[TB] FAIL rand_rd cycle=%0d got=%h want=%h", c, bus.rd_colunas, m_rd);
      end
      checks++;
      if (bus.pronto !== (!m_pending && m_clear_left == 0)) begin
        failures++;
        $display("[TB] FAIL rand_pronto cycle=%0d got=%b want=%b", c, bus.pronto, (!m_pending && m_clear_left == 0));
      end
      checks++;
      if (bus.quadro_ativo !== m_front[0]) begin
        failures++; $display("[TB] FAIL rand_qa cycle=%0d got=%b want=%b", c, bus.quadro_ativo, m_front[0]);
      end
      checks++;
      if (bus.troca !== m_troca) begin
        failures++; $display("[TB] FAIL rand_troca cycle=%0d got=%b want=%b", c, bus.troca, m_troca);
      end
    end
    reset = 1'b0;
    idle();
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    idle();
    m_front = 0; m_pending = 0; m_clear_left = 0; m_rd = 5'd0; m_troca = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 7; r++)
        m_bank[b][r] = 5'd0;
    test_reset();
    test_write_commit();
    test_commit_boundary();
    test_pending_drops();
    test_clear();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
